// File: rtl/tft_timing_gen_if.sv
// Control and timing-output bundle of the TFT timing generator.
// master = generator side, slave = consumer side.
interface tft_timing_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          iCke;
  logic          iEnable;
  logic          oVde;
  logic          oFvde;
  logic          oFe;
  logic          oHsync;
  logic          oVsync;
  logic [HW-1:0] oHpos;
  logic [VW-1:0] oVpos;
  logic          oBusy;

  modport master (
    input  iCke, iEnable,
    output oVde, oFvde, oFe, oHsync, oVsync, oHpos, oVpos, oBusy
  );

  modport slave (
    output iCke, iEnable,
    input  oVde, oFvde, oFe, oHsync, oVsync, oHpos, oVpos, oBusy
  );
endinterface

// File: rtl/tft_timing_gen.sv
// Parametrised TFT raster timing generator: H/V counters, registered decodes,
// and an IDLE/RUN/DRAIN controller that only ever stops on a frame boundary.
module tft_timing_gen #(
  parameter int pHdisplay = 640,
  parameter int pHfront   = 16,
  parameter int pHsync    = 96,
  parameter int pHback    = 48,
  parameter int pVdisplay = 480,
  parameter int pVbottom  = 11,
  parameter int pVsync    = 2,
  parameter int pVtop     = 31,
  parameter int pHsyncPol = 0,
  parameter int pVsyncPol = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  tft_timing_gen_if.master  bus
);
  localparam int HT = pHdisplay + pHfront + pHsync + pHback;
  localparam int VT = pVdisplay + pVbottom + pVsync + pVtop;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [31:0] HDISP = pHdisplay;
  localparam logic [31:0] VDISP = pVdisplay;
  localparam logic [31:0] HSS   = pHdisplay + pHfront;
  localparam logic [31:0] HSE   = pHdisplay + pHfront + pHsync;
  localparam logic [31:0] VSS   = pVdisplay + pVbottom;
  localparam logic [31:0] VSE   = pVdisplay + pVbottom + pVsync;
  localparam logic        HPOL  = (pHsyncPol != 0);
  localparam logic        VPOL  = (pVsyncPol != 0);
  localparam logic [HW-1:0] HMAX = HW'(HT - 1);
  localparam logic [VW-1:0] VMAX = VW'(VT - 1);

  logic [1:0]    state, state_nxt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          adv, hwrap, vwrap, fwrap;
  logic          h_act, v_act, hs_act, vs_act;

  assign adv    = (state != S_IDLE) && bus.iCke;
  assign hwrap  = (hcnt == HMAX);
  assign vwrap  = (vcnt == VMAX);
  assign fwrap  = adv && hwrap && vwrap;
  assign h_act  = 32'(hcnt) < HDISP;
  assign v_act  = 32'(vcnt) < VDISP;
  assign hs_act = (32'(hcnt) >= HSS) && (32'(hcnt) < HSE);
  assign vs_act = (32'(vcnt) >= VSS) && (32'(vcnt) < VSE);

  // Enable wins over a coincident frame-end wrap, so a re-armed DRAIN never idles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.iEnable) state_nxt = S_RUN;
      S_RUN:   if (!bus.iEnable) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (bus.iEnable)  state_nxt = S_RUN;
        else if (fwrap)   state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (state == S_IDLE) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (bus.iCke) begin
      if (hwrap) begin
        hcnt <= '0;
        vcnt <= vwrap ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Decodes sample the counters only on advancing cycles, so they stay aligned
  // with oHpos/oVpos one iClk after the enabling iCke.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      bus.oVde   <= 1'b0;
      bus.oFvde  <= 1'b0;
      bus.oFe    <= 1'b0;
      bus.oHsync <= ~HPOL;
      bus.oVsync <= ~VPOL;
      bus.oHpos  <= '0;
      bus.oVpos  <= '0;
      bus.oBusy  <= 1'b0;
    end else begin
      bus.oFe   <= fwrap;
      bus.oBusy <= (state != S_IDLE);
      if (state == S_IDLE) begin
        bus.oVde   <= 1'b0;
        bus.oFvde  <= 1'b0;
        bus.oHsync <= ~HPOL;
        bus.oVsync <= ~VPOL;
        bus.oHpos  <= '0;
        bus.oVpos  <= '0;
      end else if (bus.iCke) begin
        bus.oVde   <= h_act && v_act;
        bus.oFvde  <= v_act;
        bus.oHsync <= hs_act ? HPOL : ~HPOL;
        bus.oVsync <= vs_act ? VPOL : ~VPOL;
        bus.oHpos  <= hcnt;
        bus.oVpos  <= vcnt;
      end
    end
  end
endmodule

// File: tb/tb_tft_timing_gen.sv
// Scoreboard bench for tft_timing_gen on a 16x8 raster; a second instance with
// active-high syncs runs in lockstep.
module tb_tft_timing_gen;
  localparam int HD = 8, HF = 2, HS = 3, HB = 3;
  localparam int VD = 4, VB = 1, VS = 2, VTP = 1;
  localparam int HT = 16, VT = 8, FR = HT * VT;
  localparam int HW = 4, VW = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

  typedef struct packed {
    logic vde, fvde, fe, hs, vs, busy;
    logic [HW-1:0] hp;
    logic [VW-1:0] vp;
  } exp_t;

  localparam exp_t RST_E    = {6'b000110, 4'd0, 3'd0};
  localparam exp_t POL_MASK = {6'b000110, 4'd0, 3'd0};

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic cke  = 1'b1;
  logic en   = 1'b0;
  always #5 iClk = ~iClk;

  tft_timing_gen_if #(.HW(HW), .VW(VW)) bus0();
  tft_timing_gen_if #(.HW(HW), .VW(VW)) bus1();
  assign bus0.iCke = cke;
  assign bus0.iEnable = en;
  assign bus1.iCke = cke;
  assign bus1.iEnable = en;

  tft_timing_gen #(.pHdisplay(HD), .pHfront(HF), .pHsync(HS), .pHback(HB),
                   .pVdisplay(VD), .pVbottom(VB), .pVsync(VS), .pVtop(VTP),
                   .pHsyncPol(0), .pVsyncPol(0))
    dut0 (.iClk(iClk), .iRst(iRst), .bus(bus0));
  tft_timing_gen #(.pHdisplay(HD), .pHfront(HF), .pHsync(HS), .pHback(HB),
                   .pVdisplay(VD), .pVbottom(VB), .pVsync(VS), .pVtop(VTP),
                   .pHsyncPol(1), .pVsyncPol(1))
    dut1 (.iClk(iClk), .iRst(iRst), .bus(bus1));

  exp_t obs0, obs1;
  assign obs0 = {bus0.oVde, bus0.oFvde, bus0.oFe, bus0.oHsync, bus0.oVsync, bus0.oBusy, bus0.oHpos, bus0.oVpos};
  assign obs1 = {bus1.oVde, bus1.oFvde, bus1.oFe, bus1.oHsync, bus1.oVsync, bus1.oBusy, bus1.oHpos, bus1.oVpos};

  int n_vec = 0, n_err = 0;
  int cyc = 0, cke_div = 1, scale = 1, fe_total = 0;
  bit mon = 1'b0;
  logic [1:0] m_st;
  int m_pos;
  exp_t m_last;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_rst();
    m_st = S_IDLE;
    m_pos = 0;
    m_last = RST_E;
    sb.delete();
  endtask

  // One iClk: advance the reference raster on the edge, then update inputs.
  task automatic step();
    exp_t e;
    logic run, wrap;
    int h, v;
    @(posedge iClk);
    if (iRst) begin
      run  = (m_st != S_IDLE) && cke;
      wrap = run && (m_pos == FR - 1);
      h = m_pos % HT;
      v = m_pos / HT;
      e = m_last;
      if (m_st == S_IDLE) begin
        e.vde = 0; e.fvde = 0; e.hs = 1; e.vs = 1; e.hp = '0; e.vp = '0;
      end else if (cke) begin
        e.vde  = (h < HD) && (v < VD);
        e.fvde = (v < VD);
        e.hs   = !(h >= HD + HF && h < HD + HF + HS);
        e.vs   = !(v >= VD + VB && v < VD + VB + VS);
        e.hp   = HW'(h);
        e.vp   = VW'(v);
      end
      e.fe   = wrap;
      e.busy = (m_st != S_IDLE);
      sb.push_back(e);
      m_last = e;
      if (run) m_pos = (m_pos + 1) % FR;
      case (m_st)
        S_IDLE:  if (en) m_st = S_RUN;
        S_RUN:   if (!en) m_st = S_DRAIN;
        default: if (en) m_st = S_RUN; else if (wrap) m_st = S_IDLE;
      endcase
    end
    cyc++;
    #1;
    if (cke_div > 1)       cke = ((cyc % cke_div) == 0);
    else if (cke_div == 1) cke = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input int p, input int lim);
    int i = 0;
    while (m_pos != p && i < lim) begin step(); i++; end
    if (m_pos != p) chk("wait_pos_timeout", m_pos, p);
  endtask

  task automatic wait_idle(input int lim);
    int i = 0;
    while ((bus0.oBusy || m_st != S_IDLE) && i < lim) begin step(); i++; end
    if (bus0.oBusy) chk("idle_timeout", 32'(bus0.oBusy), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 32'(obs0), 32'(RST_E));
    chk({tag, "_pol"}, 32'(obs1), 32'(RST_E ^ POL_MASK));
  endtask

  task automatic restart_mon();
    mon = 1'b0;
    step();
    mon = 1'b1;
  endtask

  // Output checker plus independent length/period monitors on dut0.
  initial begin
    exp_t e;
    int ncyc = 0, last_fe = -1, vde_cnt = 0, vde_run = 0, hs_run = 0, vs_run = 0, fe_run = 0;
    logic p_fe = 0, p_vde = 0, p_hs = 1, p_vs = 1;
    forever begin
      @(negedge iClk);
      ncyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("outs", 32'(obs0), 32'(e));
        chk("pol_outs", 32'(obs1), 32'(e ^ POL_MASK));
      end
      if (bus0.oFe && !p_fe) fe_total++;
      if (!mon) begin
        last_fe = -1; vde_cnt = 0; vde_run = 0; hs_run = 0; vs_run = 0; fe_run = 0;
      end else begin
        if (bus0.oFe && !p_fe) begin
          if (last_fe >= 0) chk("fe_period", ncyc - last_fe, FR * scale);
          last_fe = ncyc;
          chk("vde_frame", vde_cnt, 4 * HD * scale);
          vde_cnt = 0;
        end
        if (!bus0.oFe && p_fe) chk("fe_width", fe_run, 1);
        if (!bus0.oVde && p_vde) chk("vde_run", vde_run, HD * scale);
        if (bus0.oHsync && !p_hs) chk("hs_run", hs_run, HS * scale);
        if (bus0.oVsync && !p_vs) chk("vs_run", vs_run, VS * HT * scale);
        fe_run  = bus0.oFe    ? fe_run + 1  : 0;
        vde_run = bus0.oVde   ? vde_run + 1 : 0;
        hs_run  = !bus0.oHsync ? hs_run + 1 : 0;
        vs_run  = !bus0.oVsync ? vs_run + 1 : 0;
        if (bus0.oVde) vde_cnt++;
      end
      p_fe = bus0.oFe; p_vde = bus0.oVde; p_hs = bus0.oHsync; p_vs = bus0.oVsync;
    end
  end

  initial begin
    int fe0, cnt;
    model_rst();
    // reset held, then 20 idle cycles after release
    steps(3);
    #3 chk_reset("rst_hold");
    step();
    iRst = 1'b1;
    steps(20);
    chk_reset("rst_idle");

    // free-running frames
    restart_mon();
    fe0 = fe_total;
    en = 1'b1;
    steps(3 * FR + 10);
    chk("fe_count", fe_total - fe0, 3);

    // graceful stop at vcnt=2, hcnt=5
    wait_pos(2 * HT + 5, 2 * FR);
    fe0 = fe_total;
    en = 1'b0;
    wait_idle(2 * FR);
    chk("stop_fe", fe_total - fe0, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt += int'(bus0.oVde); end
    chk("post_stop_vde", cnt, 0);

    // re-raise during drain: frames continue back to back
    restart_mon();
    en = 1'b1;
    wait_pos(50, 2 * FR);
    en = 1'b0;
    steps(30);
    en = 1'b1;
    steps(200);
    chk("rearm_busy", 32'(bus0.oBusy), 1);

    // DRAIN wrap coinciding with enable goes back to RUN
    wait_pos(60, 2 * FR);
    en = 1'b0;
    wait_pos(FR - 1, 2 * FR);
    en = 1'b1;
    steps(150);
    chk("wrap_rearm_busy", 32'(bus0.oBusy), 1);

    // enable dropped on the wrap cycle: one more full frame
    wait_pos(FR - 1, 2 * FR);
    fe0 = fe_total;
    en = 1'b0;
    wait_idle(3 * FR);
    chk("drain_frames", fe_total - fe0, 2);

    // iCke every third clock
    cke_div = 3;
    scale = 3;
    restart_mon();
    fe0 = fe_total;
    en = 1'b1;
    steps(3 * 3 * FR + 30);
    chk("cke3_fe_count", fe_total - fe0, 3);
    en = 1'b0;
    wait_idle(4 * 3 * FR);

    // async reset mid-line with iCke low
    mon = 1'b0;
    cke_div = 1;
    scale = 1;
    en = 1'b1;
    step();
    wait_pos(HT + 6, 2 * FR);
    cke_div = 0;
    cke = 1'b0;
    steps(3);
    chk("cke_hold_hpos", 32'(bus0.oHpos), 5);
    #1;
    iRst = 1'b0;
    model_rst();
    #1 chk_reset("async_rst");
    steps(2);
    en = 1'b0;
    cke_div = 1;
    step();
    iRst = 1'b1;
    steps(5);
    chk_reset("post_async_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
